// File: rtl/tb_ctrl_pkg.sv
// Shared definitions for the testbench run controller: FSM states, register map
// and CTRL/STATUS bit positions.
package tb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } run_state_t;

  localparam logic [3:0] ADDR_CTRL        = 4'h0;
  localparam logic [3:0] ADDR_NUM_VECTORS = 4'h4;
  localparam logic [3:0] ADDR_STATUS      = 4'h8;
  localparam logic [3:0] ADDR_VEC_COUNT   = 4'hC;

  localparam int CTRL_START       = 0;
  localparam int CTRL_ABORT       = 1;
  localparam int CTRL_STOP_ON_ERR = 2;
  localparam int CTRL_ACK         = 3;

  // The status word is a 31-bit concatenation, so the error count lands at [30:15].
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ERR_SEEN = 2;
  localparam int STAT_ABORTED  = 3;
  localparam int STAT_ERR_LSB  = 15;

  function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                              input logic err_seen, input logic aborted,
                                              input logic [15:0] err_count);
    logic [31:0] status;
    status = '0;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = done;
    status[STAT_ERR_SEEN] = err_seen;
    status[STAT_ABORTED] = aborted;
    status[STAT_ERR_LSB +: 16] = err_count;
    return status;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tb_run_controller.sv
// Avalon-controlled sequencer for a verification run: clear the scoreboard, enable
// stimulus for NUM_VECTORS cycles, let the pipeline drain, then report status.
module tb_run_controller
  import tb_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DRAIN_CYCLES = 4,
  parameter logic [WIDTH-1:0] ERR_MASK     = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       slave_address,
  input  logic             slave_read,
  input  logic             slave_write,
  input  logic [WIDTH-1:0] slave_writedata,
  output logic [WIDTH-1:0] slave_readdata,
  input  logic [WIDTH-1:0] i_event,
  output logic             o_enable,
  output logic             o_clear
);

  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  localparam run_state_t  AFTER_RUN  = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;

  run_state_t  state, state_next;
  logic [31:0] wdata32;
  logic [31:0] num_vectors, vec_count, drain_cnt;
  logic [15:0] err_count;
  logic        stop_on_error, err_seen, aborted;
  logic        rd_en, wr_en, ctrl_wr;
  logic        start_req, abort_req, ack_req;
  logic        busy, active, done, start_go, zero_start;
  logic        last_vector, err_hit, err_clear, err_inc;

  assign wdata32   = 32'(slave_writedata);
  assign rd_en     = slave_read && !slave_write;
  assign wr_en     = slave_write && !slave_read;
  assign ctrl_wr   = wr_en && (slave_address == ADDR_CTRL);
  // Abort wins over start when both arrive in one write.
  assign start_req = ctrl_wr && wdata32[CTRL_START] && !wdata32[CTRL_ABORT];
  assign abort_req = ctrl_wr && wdata32[CTRL_ABORT];
  assign ack_req   = ctrl_wr && wdata32[CTRL_ACK];

  assign busy        = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_DRAIN);
  assign active      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done        = (state == ST_DONE);
  assign start_go    = start_req && ((state == ST_IDLE) || (state == ST_DONE));
  assign zero_start  = start_go && (num_vectors == '0);
  assign last_vector = ((vec_count + 32'd1) == num_vectors);
  assign err_hit     = |(i_event & ERR_MASK);
  assign err_clear   = (state == ST_CLEAR) || zero_start;
  assign err_inc     = active && err_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_enable   = 1'b0;
    o_clear    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_go) state_next = zero_start ? ST_DONE : ST_CLEAR;
      end
      ST_CLEAR: begin
        o_clear    = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        o_enable = 1'b1;
        if (abort_req) begin
          state_next = ST_DONE;
        end else if (last_vector || (stop_on_error && err_hit)) begin
          state_next = AFTER_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort_req || (drain_cnt == DRAIN_LAST)) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start_go) begin
          state_next = zero_start ? ST_DONE : ST_CLEAR;
        end else if (ack_req) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A vector presented in the same cycle as an abort is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_vectors   <= '0;
      vec_count     <= '0;
      drain_cnt     <= '0;
      stop_on_error <= 1'b0;
      err_seen      <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      if (wr_en && (slave_address == ADDR_NUM_VECTORS) && !busy) num_vectors <= wdata32;
      if (ctrl_wr) stop_on_error <= wdata32[CTRL_STOP_ON_ERR];
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 32'd1 : '0;
      if (err_clear) begin
        vec_count <= '0;
        err_seen  <= 1'b0;
        aborted   <= 1'b0;
      end else begin
        if ((state == ST_RUN) && !abort_req) vec_count <= vec_count + 32'd1;
        if (err_inc) err_seen <= 1'b1;
        if (active && abort_req) aborted <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(16)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .clear (err_clear),
    .inc   (err_inc),
    .count (err_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slave_readdata <= '0;
    end else if (rd_en) begin
      case (slave_address)
        ADDR_NUM_VECTORS: slave_readdata <= WIDTH'(num_vectors);
        ADDR_STATUS:      slave_readdata <= WIDTH'(pack_status(busy, done, err_seen, aborted, err_count));
        ADDR_VEC_COUNT:   slave_readdata <= WIDTH'(vec_count);
        default:          slave_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_run_controller.sv
// Randomised and directed bench for tb_run_controller, checked every cycle against a
// run-level behavioural model (phase counters rather than FSM states).
module tb_tb_run_controller;

  localparam int          DRAIN    = 4;
  localparam logic [31:0] ERR_BITS = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  slave_address = 4'h0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'h0;
  logic [31:0] slave_readdata;
  logic [31:0] i_event = 32'h0;
  logic        o_enable;
  logic        o_clear;

  int n_compared = 0;
  int n_mismatched = 0;

  // Model: a run is a clear phase, then m_left vectors, then m_drain flush cycles.
  int unsigned m_num = 0, m_vec = 0, m_left = 0, m_drain = 0, m_err = 0;
  bit          m_clear = 0, m_done = 0, m_err_seen = 0, m_aborted = 0, m_stop = 0;
  logic [31:0] m_rdata = 32'h0;

  tb_run_controller #(
    .WIDTH        (32),
    .DRAIN_CYCLES (DRAIN),
    .ERR_MASK     (ERR_BITS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .slave_address   (slave_address),
    .slave_read      (slave_read),
    .slave_write     (slave_write),
    .slave_writedata (slave_writedata),
    .slave_readdata  (slave_readdata),
    .i_event         (i_event),
    .o_enable        (o_enable),
    .o_clear         (o_clear)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      if (n_mismatched <= 40)
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit model_busy();
    return m_clear || (m_left > 0) || (m_drain > 0);
  endfunction

  function automatic bit model_enable();
    return !m_clear && (m_left > 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    case (addr)
      4'h4:    return m_num;
      4'h8:    return (m_err << 15) | (32'(m_aborted) << 3) | (32'(m_err_seen) << 2) |
                      (32'(m_done) << 1) | 32'(model_busy());
      4'hC:    return m_vec;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_num = 0; m_vec = 0; m_left = 0; m_drain = 0; m_err = 0;
    m_clear = 0; m_done = 0; m_err_seen = 0; m_aborted = 0; m_stop = 0;
    m_rdata = 32'h0;
  endtask

  task automatic model_step();
    bit rd, wr, err, in_run, in_drain, busy_pre, start, abort, ack;
    rd       = slave_read && !slave_write;
    wr       = slave_write && !slave_read;
    err      = (i_event & ERR_BITS) != 0;
    in_run   = model_enable();
    in_drain = !m_clear && (m_left == 0) && (m_drain > 0);
    busy_pre = model_busy();
    start    = wr && (slave_address == 4'h0) && slave_writedata[0] && !slave_writedata[1];
    abort    = wr && (slave_address == 4'h0) && slave_writedata[1];
    ack      = wr && (slave_address == 4'h0) && slave_writedata[3];
    if (rd) m_rdata = model_read(slave_address);
    if ((in_run || in_drain) && err) begin
      if (m_err < 65535) m_err++;
      m_err_seen = 1;
    end
    if (in_run) begin
      if (abort) begin
        m_left = 0; m_drain = 0; m_done = 1; m_aborted = 1;
      end else begin
        m_vec++;
        m_left--;
        if ((m_left == 0) || (m_stop && err)) begin
          m_left = 0;
          m_drain = DRAIN;
          if (DRAIN == 0) m_done = 1;
        end
      end
    end else if (in_drain) begin
      if (abort) begin
        m_drain = 0; m_done = 1; m_aborted = 1;
      end else begin
        m_drain--;
        if (m_drain == 0) m_done = 1;
      end
    end else if (m_clear) begin
      m_clear = 0; m_vec = 0; m_err = 0; m_err_seen = 0; m_aborted = 0;
    end else if (start) begin
      if (m_num == 0) begin
        m_done = 1; m_vec = 0; m_err = 0; m_err_seen = 0; m_aborted = 0;
      end else begin
        m_clear = 1; m_left = m_num; m_done = 0;
      end
    end else if (ack && m_done) begin
      m_done = 0;
    end
    if (wr && (slave_address == 4'h4) && !busy_pre) m_num = slave_writedata;
    if (wr && (slave_address == 4'h0)) m_stop = slave_writedata[2];
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    checkOutput("o_enable", 32'(o_enable), 32'(model_enable()));
    checkOutput("o_clear", 32'(o_clear), 32'(m_clear));
    checkOutput("slave_readdata", slave_readdata, m_rdata);
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] addr,
                               input logic [31:0] wdata, input logic [31:0] evt);
    @(negedge clk);
    #1;
    slave_read = rd;
    slave_write = wr;
    slave_address = addr;
    slave_writedata = wdata;
    i_event = evt;
  endtask

  task automatic idle_cycle(input logic [31:0] evt);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, evt);
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, addr, data, 32'h0);
  endtask

  task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 32'h0);
    idle_cycle(32'h0);
    data = slave_readdata;
  endtask

  initial begin
    logic [31:0] rd_data;
    int n_en, n_clr;

    repeat (3) idle_cycle(32'h0);
    checkOutput("rst_enable", 32'(o_enable), 32'h0);
    checkOutput("rst_readdata", slave_readdata, 32'h0);
    @(negedge clk); #1; reset = 1'b1;
    read_reg(4'h8, rd_data); checkOutput("rst_status", rd_data, 32'h0);
    read_reg(4'h4, rd_data); checkOutput("rst_num", rd_data, 32'h0);

    // Ten vectors, no events.
    write_reg(4'h4, 32'd10);
    write_reg(4'h0, 32'h1);
    n_en = 0; n_clr = 0;
    for (int i = 0; i < 25; i++) begin
      idle_cycle(32'h0);
      n_en += int'(o_enable);
      n_clr += int'(o_clear);
    end
    checkOutput("s1_clear_cycles", 32'(n_clr), 32'd1);
    checkOutput("s1_enable_cycles", 32'(n_en), 32'd10);
    read_reg(4'hC, rd_data); checkOutput("s1_vec_count", rd_data, 32'd10);
    read_reg(4'h8, rd_data); checkOutput("s1_status", rd_data, 32'h2);
    checkOutput("s1_model_vec", m_vec, 32'd10);

    // Errors on RUN cycle 5 and on DRAIN cycle 101.
    write_reg(4'h4, 32'd100);
    write_reg(4'h0, 32'h1);
    idle_cycle(32'h0);
    for (int j = 0; j < 120; j++) idle_cycle((j == 5 || j == 101) ? 32'h1 : 32'h0);
    read_reg(4'h8, rd_data); checkOutput("s2_status", rd_data, 32'h0001_0006);
    read_reg(4'hC, rd_data); checkOutput("s2_vec_count", rd_data, 32'd100);
    checkOutput("s2_model_err", m_err, 32'd2);

    // stop_on_error with an error on RUN cycle 7, then ack.
    write_reg(4'h4, 32'd1000);
    write_reg(4'h0, 32'h5);
    idle_cycle(32'h0);
    n_en = 0;
    for (int j = 0; j < 30; j++) begin
      idle_cycle((j == 7) ? 32'h1 : 32'h0);
      n_en += int'(o_enable);
    end
    checkOutput("s3_enable_cycles", 32'(n_en), 32'd8);
    read_reg(4'hC, rd_data); checkOutput("s3_vec_count", rd_data, 32'd8);
    read_reg(4'h8, rd_data); checkOutput("s3_status", rd_data, 32'h0000_8006);
    write_reg(4'h0, 32'h8);
    read_reg(4'h8, rd_data); checkOutput("s3_status_after_ack", rd_data, 32'h0000_8004);

    // Abort on RUN cycle 20, with a NUM_VECTORS write attempted while busy.
    write_reg(4'h4, 32'd50);
    write_reg(4'h0, 32'h1);
    idle_cycle(32'h0);
    for (int j = 0; j < 20; j++) begin
      if (j == 10) write_reg(4'h4, 32'd7);
      else idle_cycle(32'h0);
    end
    write_reg(4'h0, 32'h2);
    idle_cycle(32'h0);
    checkOutput("s4_enable_after_abort", 32'(o_enable), 32'h0);
    read_reg(4'h8, rd_data); checkOutput("s4_status", rd_data, 32'h0000_000A);
    read_reg(4'hC, rd_data); checkOutput("s4_vec_count", rd_data, 32'd20);
    read_reg(4'h4, rd_data); checkOutput("s4_num_unchanged", rd_data, 32'd50);

    // Zero-length run, then error-count saturation.
    write_reg(4'h4, 32'd0);
    write_reg(4'h0, 32'h1);
    idle_cycle(32'h0);
    checkOutput("s5_zero_clear", 32'(o_clear), 32'h0);
    checkOutput("s5_zero_enable", 32'(o_enable), 32'h0);
    read_reg(4'h8, rd_data); checkOutput("s5_zero_status", rd_data, 32'h2);
    read_reg(4'hC, rd_data); checkOutput("s5_zero_vec", rd_data, 32'd0);
    write_reg(4'h4, 32'd65540);
    write_reg(4'h0, 32'h1);
    for (int j = 0; j < 65550; j++) idle_cycle(32'h1);
    read_reg(4'h8, rd_data); checkOutput("s5_sat_status", rd_data, 32'h7FFF_8006);
    read_reg(4'hC, rd_data); checkOutput("s5_sat_vec", rd_data, 32'd65540);

    // Asynchronous reset in the middle of a run.
    write_reg(4'h4, 32'd30);
    write_reg(4'h0, 32'h1);
    repeat (5) idle_cycle(32'h0);
    checkOutput("s6_enable_before_reset", 32'(o_enable), 32'h1);
    @(negedge clk); #1; reset = 1'b0;
    #1 checkOutput("s6_async_enable", 32'(o_enable), 32'h0);
    repeat (2) idle_cycle(32'h0);
    @(negedge clk); #1; reset = 1'b1;
    n_clr = 0;
    for (int j = 0; j < 5; j++) begin
      idle_cycle(32'h0);
      n_clr += int'(o_clear);
    end
    checkOutput("s6_no_clear", 32'(n_clr), 32'h0);
    read_reg(4'h4, rd_data); checkOutput("s6_num", rd_data, 32'h0);
    read_reg(4'h8, rd_data); checkOutput("s6_status", rd_data, 32'h0);
    read_reg(4'hC, rd_data); checkOutput("s6_vec", rd_data, 32'h0);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      int unsigned r;
      logic [31:0] evt, data;
      logic [3:0] addr;
      r = $urandom_range(0, 99);
      evt = $urandom();
      if ($urandom_range(0, 3) != 0) evt[0] = 1'b0;
      if (r < 6) begin
        data = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) data[1] = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'h0, data, evt);
      end else if (r < 14) begin
        applyStimulus(1'b0, 1'b1, 4'h4, 32'($urandom_range(0, 12)), evt);
      end else if (r < 50) begin
        applyStimulus(1'b1, 1'b0, 4'($urandom_range(0, 15)), 32'h0, evt);
      end else if (r < 54) begin
        applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 15)), $urandom(), evt);
      end else if (r < 58) begin
        addr = 4'($urandom_range(0, 15));
        if (addr == 4'h0 || addr == 4'h4) addr = 4'h6;
        applyStimulus(1'b0, 1'b1, addr, $urandom(), evt);
      end else begin
        idle_cycle(evt);
      end
    end
    idle_cycle(32'h0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
